// File: rtl/cal_seq_pkg.sv
// cal_seq_pkg: shared types and helpers for the cal_seq_ctrl sequencer.
package cal_seq_pkg;

    localparam int CAL_ACC_W_DEF = 24;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_DRAIN = 3'd2,
        ST_BIAS  = 3'd3,
        ST_OUT   = 3'd4
    } cal_state_e;

    // Clamp a signed value (sign-extended to 64 bits) into the signed dw-bit
    // range; the result is returned sign-extended so the caller keeps the low dw bits.
    function automatic logic signed [63:0] sat_narrow(input logic signed [63:0] v, input int dw);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/cal_seq_ctrl_if.sv
// cal_seq_ctrl_if: command and result ports between the layer controller and cal_seq_ctrl.
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high; the sender holds valid and its payload stable until then and
// valid never depends combinationally on ready.
interface cal_seq_ctrl_if #(
    parameter int DW     = 16,
    parameter int ADDR_W = 6
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W:0]   cmd_nbatch;
    logic [DW-1:0]     cmd_bias;
    logic              cmd_extend;
    logic              res_valid;
    logic              res_ready;
    logic [DW-1:0]     res_data;

    modport master (
        output cmd_valid, cmd_nbatch, cmd_bias, cmd_extend, res_ready,
        input  cmd_ready, res_valid, res_data
    );

    modport slave (
        input  cmd_valid, cmd_nbatch, cmd_bias, cmd_extend, res_ready,
        output cmd_ready, res_valid, res_data
    );
endinterface

// File: rtl/cal_seq_acc.sv
// cal_seq_acc: channel accumulator, bias add and final narrowing to DW.
// Build option CAL_SEQ_SAT_EN: when defined the biased result saturates to
// the DW range, otherwise it keeps the low DW bits (two's-complement wrap).
module cal_seq_acc
    import cal_seq_pkg::*;
#(
    parameter int DW    = 16,
    parameter int ACC_W = CAL_ACC_W_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          add_en_i,
    input  logic [DW-1:0] add_val_i,
    input  logic          fin_en_i,
    input  logic [DW-1:0] bias_i,
    output logic [DW-1:0] res_o
);
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [DW-1:0]    res_q, res_d;
    logic [DW-1:0]    narrowed;

    // Accumulate sign-extended partial sums, wrapping at ACC_W bits.
    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (add_en_i) begin
            acc_d = acc_q + {{(ACC_W-DW){add_val_i[DW-1]}}, add_val_i};
        end
    end

`ifdef CAL_SEQ_SAT_EN
    logic [ACC_W-1:0]   sum_full;
    logic signed [63:0] sat_wide;
    // Full-width bias add, then clamp into the DW range.
    always_comb begin
        sum_full = acc_q + {{(ACC_W-DW){bias_i[DW-1]}}, bias_i};
        sat_wide = sat_narrow(64'(signed'(sum_full)), DW);
        narrowed = sat_wide[DW-1:0];
    end
`else
    // Low DW bits of (acc + bias) only depend on the low DW bits of each operand.
    always_comb begin
        narrowed = acc_q[DW-1:0] + bias_i;
    end
`endif

    // Capture the final result when the FSM passes through BIAS.
    always_comb begin
        res_d = res_q;
        if (fin_en_i) begin
            res_d = narrowed;
        end
    end

    // Accumulator and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            res_q <= '0;
        end else begin
            acc_q <= acc_d;
            res_q <= res_d;
        end
    end

    assign res_o = res_q;

endmodule

// File: rtl/cal_seq_ctrl.sv
// cal_seq_ctrl: issues batch reads to the compute unit, collects its partial
// sums and returns one biased, narrowed channel result per command.
// Build option CAL_SEQ_SAT_EN (see cal_seq_acc) selects saturating narrowing.
module cal_seq_ctrl
    import cal_seq_pkg::*;
#(
    parameter int DW           = 16,
    parameter int BATCH_LENGTH = 16,
    parameter int MAX_BATCHES  = 64,
    parameter int ACC_W        = CAL_ACC_W_DEF,
    parameter int ADDR_W       = $clog2(MAX_BATCHES)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    cal_seq_ctrl_if.slave              ctrl,
    output logic                       mem_rd_en,
    output logic [ADDR_W-1:0]          mem_rd_addr,
    input  logic [DW*BATCH_LENGTH-1:0] mem_din,
    input  logic [DW*BATCH_LENGTH-1:0] mem_weight,
    output logic [DW*BATCH_LENGTH-1:0] cal_din,
    output logic [DW*BATCH_LENGTH-1:0] cal_weight,
    output logic [DW-1:0]              cal_bias,
    output logic                       cal_en,
    output logic                       cal_extend_en,
    input  logic                       cal_valid,
    input  logic [DW-1:0]              cal_channel_sum,
    output logic                       busy,
    output cal_state_e                 dbg_state
);
    localparam int              CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] MAX_N = CNT_W'(MAX_BATCHES);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    cal_state_e       state_q, state_d;
    logic [CNT_W-1:0] n_q, iss_cnt_q, ret_cnt_q, n_cmd;
    logic [DW-1:0]    bias_q;
    logic             ext_q, cal_en_q;
    logic             accept, ret_en, issue_last, ret_last;

    assign n_cmd      = (ctrl.cmd_nbatch > MAX_N) ? MAX_N : ctrl.cmd_nbatch;
    assign accept     = (state_q == ST_IDLE) && ctrl.cmd_valid;
    // Returns only count while a command is collecting; stale ones are dropped.
    assign ret_en     = cal_valid && ((state_q == ST_ISSUE) || (state_q == ST_DRAIN));
    assign issue_last = (iss_cnt_q + ONE) == n_q;
    assign ret_last   = ret_en && ((ret_cnt_q + ONE) == n_q);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = (n_cmd == '0) ? ST_BIAS : ST_ISSUE;
            ST_ISSUE: begin
                if (ret_last) state_d = ST_BIAS;
                else if (issue_last) state_d = ST_DRAIN;
            end
            ST_DRAIN: if (ret_last) state_d = ST_BIAS;
            ST_BIAS:  state_d = ST_OUT;
            ST_OUT:   if (ctrl.res_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        ctrl.cmd_ready = 1'b0;
        ctrl.res_valid = 1'b0;
        mem_rd_en      = 1'b0;
        mem_rd_addr    = '0;
        busy           = 1'b1;
        case (state_q)
            ST_IDLE: begin
                ctrl.cmd_ready = 1'b1;
                busy           = 1'b0;
            end
            ST_ISSUE: begin
                mem_rd_en   = 1'b1;
                mem_rd_addr = iss_cnt_q[ADDR_W-1:0];
            end
            ST_OUT:  ctrl.res_valid = 1'b1;
            default: ;
        endcase
    end

    // Command latch and issue/return counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_q       <= '0;
            bias_q    <= '0;
            ext_q     <= 1'b0;
            iss_cnt_q <= '0;
            ret_cnt_q <= '0;
        end else if (accept) begin
            n_q       <= n_cmd;
            bias_q    <= ctrl.cmd_bias;
            ext_q     <= ctrl.cmd_extend;
            iss_cnt_q <= '0;
            ret_cnt_q <= '0;
        end else begin
            if (state_q == ST_ISSUE) iss_cnt_q <= iss_cnt_q + ONE;
            if (ret_en) ret_cnt_q <= ret_cnt_q + ONE;
        end
    end

    // cal_en lags the read strobe by one cycle to line up with read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cal_en_q <= 1'b0;
        end else begin
            cal_en_q <= mem_rd_en;
        end
    end

    cal_seq_acc #(
        .DW    (DW),
        .ACC_W (ACC_W)
    ) u_acc (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (accept),
        .add_en_i  (ret_en),
        .add_val_i (cal_channel_sum),
        .fin_en_i  (state_q == ST_BIAS),
        .bias_i    (bias_q),
        .res_o     (ctrl.res_data)
    );

    assign cal_din       = mem_din;
    assign cal_weight    = mem_weight;
    assign cal_bias      = bias_q;
    assign cal_extend_en = ext_q;
    assign cal_en        = cal_en_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_cal_seq_ctrl.sv
// tb_cal_seq_ctrl: directed and random commands against a behavioural model
// of the sequencer, the buffer and a 7-cycle compute unit.
`timescale 1ns/1ps
module tb_cal_seq_ctrl;
    import cal_seq_pkg::*;

    localparam int DW = 16, BL = 16, MAXB = 64, ACC_W = 24, ADDR_W = 6;
    localparam int BW = DW * BL;
    localparam int CU_LAT = 7;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    cal_seq_ctrl_if #(.DW(DW), .ADDR_W(ADDR_W)) ctrl_if ();
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [BW-1:0]     mem_din, mem_weight, cal_din, cal_weight;
    logic [DW-1:0]     cal_bias, cal_channel_sum;
    logic              cal_en, cal_extend_en, cal_valid, busy;
    cal_state_e        dbg_state;

    cal_seq_ctrl #(.DW(DW), .BATCH_LENGTH(BL), .MAX_BATCHES(MAXB), .ACC_W(ACC_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .ctrl(ctrl_if),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_din(mem_din), .mem_weight(mem_weight),
        .cal_din(cal_din), .cal_weight(cal_weight), .cal_bias(cal_bias), .cal_en(cal_en),
        .cal_extend_en(cal_extend_en), .cal_valid(cal_valid), .cal_channel_sum(cal_channel_sum),
        .busy(busy), .dbg_state(dbg_state)
    );

    // ---------------- scoreboard state ----------------
    logic [DW-1:0] exp_q[$];
    int            exp_t_q[$];
    logic [DW-1:0] ret_vals_q[$];
    typedef struct { int due; logic [DW-1:0] val; } ret_t;
    ret_t          pipe_q[$];
    ret_t          cu_r;

    int checks = 0, errors = 0;
    int cmd_t = 0, cmd_n = 0;
    logic [DW-1:0] cmd_b = '0;
    logic cmd_x = 1'b0;
    bit act = 1'b0;
    int done_cnt = 0, ready_delay = 0, pat_seed = 0;

    task automatic chk(input string name, input logic [BW-1:0] got, input logic [BW-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, got, want);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s cycle %0d", name, cyc);
    endtask

    function automatic logic [BW-1:0] pat(input int idx, input bit w);
        logic [BW-1:0] p;
        for (int i = 0; i < BL; i++) p[i*DW +: DW] = DW'(pat_seed + idx * 131 + i * 7 + (w ? 4099 : 0));
        return p;
    endfunction

    function automatic logic [BW-1:0] junk();
        logic [BW-1:0] p;
        for (int i = 0; i < BW / 32; i++) p[i*32 +: 32] = $urandom();
        return p;
    endfunction

    // Reference: signed sum of returns plus bias, kept modulo 2^ACC_W, then narrowed.
    function automatic logic [DW-1:0] ref_result(input logic [DW-1:0] rets[$], input logic [DW-1:0] bias);
        longint s, m;
        s = longint'(signed'(bias));
        foreach (rets[i]) s += longint'(signed'(rets[i]));
        m = longint'(1) << ACC_W;
        s = s % m;
        if (s < 0) s += m;
        if (s >= m / 2) s -= m;
`ifdef CAL_SEQ_SAT_EN
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
`endif
        return DW'(s);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic start_cmd(input int nb, input logic [DW-1:0] bias, input bit ext,
                             input logic [DW-1:0] rets[$], input int rdy_delay);
        int n_eff, w;
        n_eff = (nb > MAXB) ? MAXB : nb;
        w = 0;
        @(posedge clk); #1;
        while (ctrl_if.cmd_ready !== 1'b1 && w < 300) begin
            @(posedge clk); #1;
            w++;
        end
        if (w >= 300) begin
            fail_now("cmd_ready_timeout");
            return;
        end
        ctrl_if.cmd_valid  = 1'b1;
        ctrl_if.cmd_nbatch = (ADDR_W+1)'(nb);
        ctrl_if.cmd_bias   = bias;
        ctrl_if.cmd_extend = ext;
        ready_delay = rdy_delay;
        cmd_t = cyc; cmd_n = n_eff; cmd_b = bias; cmd_x = ext; act = 1'b1;
        foreach (rets[i]) ret_vals_q.push_back(rets[i]);
        exp_q.push_back(ref_result(rets, bias));
        exp_t_q.push_back(cyc + ((n_eff == 0) ? 2 : n_eff + 10));
        @(posedge clk); #1;
        ctrl_if.cmd_valid  = 1'b0;
        ctrl_if.cmd_nbatch = (ADDR_W+1)'($urandom);
        ctrl_if.cmd_bias   = DW'($urandom);
        ctrl_if.cmd_extend = 1'($urandom);
    endtask

    task automatic wait_done(input int bound);
        int start, w;
        start = done_cnt;
        w = 0;
        while (done_cnt == start && w < bound) begin
            @(posedge clk);
            w++;
        end
        if (done_cnt == start) fail_now("result_timeout");
    endtask

    task automatic do_reset(input int ncyc);
        @(posedge clk); #1;
        rst_n = 1'b0;
        act = 1'b0;
        exp_q.delete();
        exp_t_q.delete();
        ret_vals_q.delete();
        repeat (ncyc) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // ---------------- buffer / compute unit / result sink ----------------
    logic rd_en_s = 1'b0;
    logic [ADDR_W-1:0] rd_addr_s = '0;
    int out_age = 0;

    // Sample read strobes and compute-unit launches mid-cycle.
    always @(negedge clk) begin
        rd_en_s   = mem_rd_en;
        rd_addr_s = mem_rd_addr;
        if (rst_n && cal_en) begin
            cu_r.due = cyc + CU_LAT;
            cu_r.val = (ret_vals_q.size() > 0) ? ret_vals_q.pop_front() : DW'($urandom);
            pipe_q.push_back(cu_r);
        end
    end

    // Drive buffer data, compute-unit returns and res_ready at cycle start.
    always @(posedge clk) begin
        #1;
        if (rd_en_s) begin
            mem_din    = pat(int'(rd_addr_s), 1'b0);
            mem_weight = pat(int'(rd_addr_s), 1'b1);
        end else begin
            mem_din    = junk();
            mem_weight = junk();
        end
        if (pipe_q.size() > 0 && pipe_q[0].due == cyc) begin
            cal_valid       = 1'b1;
            cal_channel_sum = pipe_q[0].val;
            void'(pipe_q.pop_front());
        end else begin
            cal_valid       = 1'b0;
            cal_channel_sum = DW'($urandom);
        end
        if (ctrl_if.res_valid) begin
            ctrl_if.res_ready = (out_age >= ready_delay);
            out_age++;
        end else begin
            out_age = 0;
            ctrl_if.res_ready = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- monitor ----------------
    bit in_out = 1'b0, hs_pend = 1'b0;
    logic [DW-1:0] cur_exp = '0;
    int cur_t = 0;
    bit exp_rd, exp_ce;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_cmd_ready", BW'(ctrl_if.cmd_ready), BW'(1));
            chk("rst_strobes", BW'({busy, mem_rd_en, cal_en, cal_extend_en, ctrl_if.res_valid}), BW'(0));
            chk("rst_addr", BW'(mem_rd_addr), BW'(0));
            chk("rst_bias", BW'(cal_bias), BW'(0));
            chk("rst_res_data", BW'(ctrl_if.res_data), BW'(0));
            chk("rst_state", BW'(dbg_state), BW'(ST_IDLE));
            in_out = 1'b0;
            hs_pend = 1'b0;
        end else begin
            exp_rd = act && (cyc >= cmd_t + 1) && (cyc <= cmd_t + cmd_n);
            exp_ce = act && (cyc >= cmd_t + 2) && (cyc <= cmd_t + cmd_n + 1);
            chk("mem_rd_en", BW'(mem_rd_en), BW'(exp_rd));
            if (exp_rd) chk("mem_rd_addr", BW'(mem_rd_addr), BW'(cyc - cmd_t - 1));
            chk("cal_en", BW'(cal_en), BW'(exp_ce));
            if (exp_ce && cal_en) begin
                chk("cal_din", cal_din, pat(cyc - cmd_t - 2, 1'b0));
                chk("cal_weight", cal_weight, pat(cyc - cmd_t - 2, 1'b1));
            end
            if (act && cyc >= cmd_t + 1) begin
                chk("cal_bias", BW'(cal_bias), BW'(cmd_b));
                chk("cal_extend_en", BW'(cal_extend_en), BW'(cmd_x));
            end
            if (hs_pend) begin
                chk("cmd_ready_after_hs", BW'(ctrl_if.cmd_ready), BW'(1));
                chk("busy_after_hs", BW'(busy), BW'(0));
                hs_pend = 1'b0;
            end
            if (ctrl_if.res_valid) begin
                if (!in_out) begin
                    in_out = 1'b1;
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_res_valid");
                        cur_exp = ctrl_if.res_data;
                        cur_t = cyc;
                    end else begin
                        cur_exp = exp_q.pop_front();
                        cur_t = exp_t_q.pop_front();
                        chk("res_valid_time", BW'(cyc), BW'(cur_t));
                    end
                end
                chk("res_data", BW'(ctrl_if.res_data), BW'(cur_exp));
                chk("cmd_ready_in_out", BW'(ctrl_if.cmd_ready), BW'(0));
                if (ctrl_if.res_ready) begin
                    in_out = 1'b0;
                    hs_pend = 1'b1;
                    done_cnt++;
                end
            end else if (in_out) begin
                fail_now("res_valid_dropped");
                in_out = 1'b0;
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [DW-1:0] rets[$];
    int nb, n_eff;

    initial begin
        ctrl_if.cmd_valid = 1'b0; ctrl_if.cmd_nbatch = '0; ctrl_if.cmd_bias = '0;
        ctrl_if.cmd_extend = 1'b0; ctrl_if.res_ready = 1'b0;
        cal_valid = 1'b0; cal_channel_sum = '0; mem_din = '0; mem_weight = '0;
        pat_seed = int'($urandom_range(0, 65535));
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // n=1: 100 + 5
        rets = '{16'd100};
        start_cmd(1, 16'd5, 1'b1, rets, 0);
        wait_done(100);

        // n=4: 4*1000 - 20
        rets = '{16'd1000, 16'd1000, 16'd1000, 16'd1000};
        start_cmd(4, 16'hFFEC, 1'b0, rets, 0);
        wait_done(100);

        // n=4: 4*0x7000 overflows DW
        rets = '{16'h7000, 16'h7000, 16'h7000, 16'h7000};
        start_cmd(4, 16'h0000, 1'b1, rets, 1);
        wait_done(100);

        // n=0: bias only
        rets.delete();
        start_cmd(0, 16'h0123, 1'b0, rets, 0);
        wait_done(50);

        // result held for 5 cycles before the handshake
        rets = '{16'd3, 16'hFFFE};
        start_cmd(2, 16'd10, 1'b0, rets, 5);
        wait_done(100);

        // reset during ISSUE, stale returns land while idle, then a fresh command
        rets.delete();
        for (int i = 0; i < 8; i++) rets.push_back(DW'($urandom));
        start_cmd(8, 16'd77, 1'b1, rets, 0);
        repeat (4) @(posedge clk);
        do_reset(3);
        repeat (12) @(posedge clk);
        rets = '{16'd7, 16'd9};
        start_cmd(2, 16'd1, 1'b0, rets, 0);
        wait_done(100);

        // random commands, including batch counts above the clamp
        for (int k = 0; k < 25; k++) begin
            nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 12));
            n_eff = (nb > MAXB) ? MAXB : nb;
            rets.delete();
            for (int i = 0; i < n_eff; i++) begin
                if ($urandom_range(0, 1) == 1) rets.push_back(DW'($urandom));
                else rets.push_back(DW'($urandom_range(0, 40000)));
            end
            start_cmd(nb, DW'($urandom), 1'($urandom), rets, int'($urandom_range(0, 3)));
            wait_done(200);
        end

        repeat (5) @(posedge clk);
        if (exp_q.size() != 0) fail_now("results_missing");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cal_seq_ctrl.md
# cal_seq_ctrl

Sequencer and collector that drives the 16-lane multiply/adder-tree compute unit (`cal_top`) from the issue side and consumes its `valid`/`channel_sum` return. It receives a channel command, fetches `nbatch` consecutive 16-element input/weight batches from the feature/weight buffer, and streams them into the compute unit one batch per cycle. It accumulates the returned partial sums, adds the channel bias once, saturates the result, and presents one DW-bit channel result on a valid/ready port to the layer controller.

## Interface
Parameters:
- `DW`, 16: sample/weight/result width, signed two's complement.
- `BATCH_LENGTH`, 16: lanes per batch.
- `MAX_BATCHES`, 64: maximum batches per channel.
- `ACC_W`, 24: internal accumulator width; must be > DW.
- `ADDR_W`, $clog2(MAX_BATCHES): buffer address width.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  high only in IDLE.
- `cmd_nbatch`  in  ADDR_W+1  batch count, 0..MAX_BATCHES; larger values are clamped to MAX_BATCHES.
- `cmd_bias`  in  DW  channel bias.
- `cmd_extend`  in  1  value driven on `cal_extend_en` for the whole command.
- `mem_rd_en`  out  1  buffer read strobe; data returns next cycle.
- `mem_rd_addr`  out  ADDR_W  batch index 0..n-1.
- `mem_din`, `mem_weight`  in  DW*BATCH_LENGTH  buffer read data, lane i at [i*DW+:DW].
- `cal_din`, `cal_weight`  out  DW*BATCH_LENGTH  batch to the compute unit; pass-through of `mem_din`/`mem_weight`.
- `cal_bias`  out  DW  registered `cmd_bias`.
- `cal_en`  out  1  batch strobe.
- `cal_extend_en`  out  1  registered `cmd_extend`.
- `cal_valid`  in  1  return strobe.
- `cal_channel_sum`  in  DW  returned partial sum.
- `res_valid`  out  1  result handshake.
- `res_ready`  in  1  result handshake.
- `res_data`  out  DW  saturated channel result.
- `busy`  out  1  state != IDLE.

## Operation
- States: IDLE, ISSUE, DRAIN, BIAS, OUT.
- IDLE
  - On `cmd_valid & cmd_ready`, latch n, bias and extend; clear the accumulator and the issue/return counters.
  - Go to ISSUE if n>0, else to BIAS.
- ISSUE
  - `mem_rd_en`=1 each cycle; `mem_rd_addr` = issue count.
  - After n reads, go to DRAIN.
- `cal_en` is `mem_rd_en` delayed one register, so each `cal_en` aligns with its buffer read data.
- Return handling (ISSUE and DRAIN)
  - Each `cal_valid` sign-extends `cal_channel_sum` to ACC_W, adds it to the accumulator with wrap, and increments the return count.
  - When the return count reaches n, go to BIAS.
- BIAS
  - Accumulator + sign-extended bias, reduced to DW per Configuration.
  - The result is registered into `res_data`; go to OUT.
- OUT
  - `res_valid`=1; `res_data` is stable until `res_ready`.
  - On handshake, go to IDLE.
- Accumulator: ACC_W signed, wraps internally; only the final reduction saturates or truncates.
- `cal_valid` outside ISSUE/DRAIN is ignored and does not change any state.
- Returns beyond n cannot occur: the return count only advances in ISSUE/DRAIN.
- Reset mid-operation
  - State forced to IDLE; counters and accumulator cleared.
  - In-flight compute-unit results arriving after reset are ignored.

## Timing
- Reset values:
  - `cmd_ready`=1.
  - `busy`, `mem_rd_en`, `mem_rd_addr`, `cal_en`, `cal_extend_en`, `cal_bias`, `res_valid`, `res_data` all = 0.
- Command accepted at edge T: `mem_rd_en` is high for cycles T+1..T+n, and `cal_en` is high for cycles T+2..T+n+1.
- With the compute unit's 7-cycle latency, returns occur in cycles T+9..T+n+8.
- `res_valid` rises exactly 2 cycles after the cycle of the last `cal_valid`, i.e. T+n+10.
- n=0: `res_valid` rises at T+2.
- `cmd_ready` falls the cycle after acceptance and returns high the cycle after the `res_valid & res_ready` edge.
- Back-to-back commands therefore incur at least one idle cycle.

## Configuration
- `CAL_SEQ_SAT_EN` defined:
  - BIAS result is clamped to [-2^(DW-1), 2^(DW-1)-1].
- `CAL_SEQ_SAT_EN` undefined:
  - BIAS result is the low DW bits (two's-complement wrap).

## Structure
- Package `cal_seq_pkg`:
  - state enum;
  - default `ACC_W`;
  - the saturating narrow function `sat_narrow(ACC_W→DW)`.
- Sub-module `cal_seq_acc`: accumulator, bias add and final narrowing (macro-dependent). The FSM and counters stay in the top.

## Test plan
- n=1, compute unit returns 100, bias 5 -> `res_data`=105; `res_valid` at T+11.
- n=4, returns 1000 each, bias -20 -> `res_data`=3980; `mem_rd_addr` 0,1,2,3 on consecutive cycles; exactly 4 `cal_en` pulses.
- n=4, returns 0x7000 each, bias 0 -> 0x7FFF with `CAL_SEQ_SAT_EN`; 0xC000 without.
- n=0, bias 0x0123 -> `res_data`=0x0123 at T+2; no `mem_rd_en` or `cal_en` pulse.
- OUT with `res_ready` low for 5 cycles -> `res_valid`/`res_data` stable, `cmd_ready`=0; handshake at cycle 6 -> `cmd_ready`=1 next cycle.
- `rst_n` low during ISSUE of n=8, then a new n=2 command with returns 7 and 9, bias 1 -> all outputs 0 during reset; stale returns ignored; `res_data`=17.
